// File: rtl/key_pkg.sv
// Shared constants, state encoding and column-strobe helper for the keypad
// scan controller and its column decoder.
package key_pkg;

  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 5;
  localparam int COL_IDX_W = $clog2(NUM_COLS);

  localparam logic [NUM_COLS-1:0] COL0    = 4'b1110;
  localparam logic [NUM_COLS-1:0] COL1    = 4'b1101;
  localparam logic [NUM_COLS-1:0] COL2    = 4'b1011;
  localparam logic [NUM_COLS-1:0] COL3    = 4'b0111;
  localparam logic [NUM_COLS-1:0] COL_OFF = 4'b1111;

  localparam logic [NUM_ROWS-1:0] ROW_IDLE = 5'b11111;
  localparam logic [NUM_ROWS-1:0] ROW_PAIR = 5'b01110;
  localparam logic [NUM_ROWS-1:0] ROW_LOW0 = 5'b11110;

  localparam logic [4:0] KEY_NONE      = 5'd0;
  localparam logic [4:0] KEY_PAIR_BASE = 5'd21;
  localparam logic [4:0] KEY_COMBO     = 5'd25;

  typedef enum logic {
    SCAN    = 1'b0,
    RESOLVE = 1'b1
  } key_state_e;

  function automatic logic [NUM_COLS-1:0] col_strobe(input logic [COL_IDX_W-1:0] idx);
    case (idx)
      2'd0:    col_strobe = COL0;
      2'd1:    col_strobe = COL1;
      2'd2:    col_strobe = COL2;
      default: col_strobe = COL3;
    endcase
  endfunction

endpackage

// File: rtl/key_col_decode.sv
// Combinational decode of one column's sampled row pattern into idle / hit /
// error and a key code.
module key_col_decode
  import key_pkg::*;
(
  input  logic [COL_IDX_W-1:0] i_col,
  input  logic [NUM_ROWS-1:0]  i_row,
  output logic                 o_idle,
  output logic                 o_hit,
  output logic                 o_err,
  output logic [4:0]           o_code
);

  logic [NUM_ROWS-1:0] w_low;
  logic                w_single;
  logic                w_pair;
  logic [2:0]          w_row_idx;
  logic [4:0]          w_col_base;

  assign w_low      = ~i_row;
  assign w_single   = $onehot(w_low);
  assign w_pair     = (i_row == ROW_PAIR);
  assign w_col_base = {1'b0, i_col, 2'b00} + {3'b000, i_col};

  always_comb begin
    w_row_idx = 3'd0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      if (w_low[i]) w_row_idx = 3'(i);
    end
  end

  always_comb begin
    o_idle = (i_row == ROW_IDLE);
    o_hit  = w_single || w_pair;
    o_err  = !o_idle && !o_hit;
    o_code = KEY_NONE;
    if (w_single) begin
      o_code = w_col_base + {2'b00, w_row_idx} + 5'd1;
    end else if (w_pair) begin
      o_code = KEY_PAIR_BASE + {3'b000, i_col};
    end
  end

endmodule

// File: rtl/key_scan_ctrl.sv
// Matrix keypad scanner: strobes columns, accumulates a frame of row samples,
// resolves a frame candidate and debounces it into committed press/release.
module key_scan_ctrl
  import key_pkg::*;
#(
  parameter int SCAN_DIV        = 10000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                scan_en,
  input  logic [NUM_ROWS-1:0] key_row_in,
  output logic [NUM_COLS-1:0] key_column_out,
  output logic [4:0]          key_code,
  output logic                key_pressed,
  output logic                key_valid,
  output key_state_e          dbg_state
);

  localparam logic [15:0] DWELL_LAST = 16'(SCAN_DIV - 1);
  localparam logic [3:0]  STABLE_MAX = 4'(DEBOUNCE_FRAMES);

  key_state_e           r_state;
  key_state_e           w_state_nxt;
  logic                 r_active;
  logic [15:0]          r_cnt;
  logic [COL_IDX_W-1:0] r_col_idx;
  logic [2:0]           r_hit_cnt;
  logic                 r_err;
  logic [4:0]           r_hit_code;
  logic                 r_c0_low0;
  logic                 r_c1_low0;
  logic [4:0]           r_prev_cand;
  logic [3:0]           r_stable;
  logic [4:0]           r_key_code;
  logic                 r_key_pressed;
  logic                 r_key_valid;

  logic                 w_scanning;
  logic                 w_last_dwell;
  logic                 w_resolve;
  logic                 w_dec_idle;
  logic                 w_dec_hit;
  logic                 w_dec_err;
  logic [4:0]           w_dec_code;
  logic [4:0]           w_cand;
  logic [3:0]           w_stable_nxt;
  logic                 w_commit;

  key_col_decode u_col_decode (
    .i_col  (r_col_idx),
    .i_row  (key_row_in),
    .o_idle (w_dec_idle),
    .o_hit  (w_dec_hit),
    .o_err  (w_dec_err),
    .o_code (w_dec_code)
  );

  // r_active is low for exactly the cycles where the strobes are parked off;
  // the first enabled cycle only re-arms it so column 0 starts at count 0.
  assign w_scanning   = scan_en && r_active;
  assign w_last_dwell = (r_cnt == DWELL_LAST);
  assign w_resolve    = w_scanning && (r_state == RESOLVE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= SCAN;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!w_scanning) begin
      w_state_nxt = SCAN;
    end else begin
      case (r_state)
        SCAN:    if (w_last_dwell && (r_col_idx == 2'd3)) w_state_nxt = RESOLVE;
        RESOLVE: w_state_nxt = SCAN;
        default: w_state_nxt = SCAN;
      endcase
    end
  end

  always_comb begin
    w_cand = KEY_NONE;
    if (!r_err) begin
      if (r_hit_cnt == 3'd1) begin
        w_cand = r_hit_code;
      end else if ((r_hit_cnt == 3'd2) && r_c0_low0 && r_c1_low0) begin
        w_cand = KEY_COMBO;
      end
    end
  end

  always_comb begin
    w_stable_nxt = 4'd1;
    if (w_cand == r_prev_cand) begin
      w_stable_nxt = (r_stable >= STABLE_MAX) ? STABLE_MAX : r_stable + 4'd1;
    end
  end

  assign w_commit = w_resolve && (w_stable_nxt == STABLE_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_active      <= 1'b1;
      r_cnt         <= '0;
      r_col_idx     <= '0;
      r_hit_cnt     <= '0;
      r_err         <= 1'b0;
      r_hit_code    <= KEY_NONE;
      r_c0_low0     <= 1'b0;
      r_c1_low0     <= 1'b0;
      r_prev_cand   <= KEY_NONE;
      r_stable      <= '0;
      r_key_code    <= KEY_NONE;
      r_key_pressed <= 1'b0;
      r_key_valid   <= 1'b0;
    end else if (!scan_en) begin
      r_active      <= 1'b0;
      r_cnt         <= '0;
      r_col_idx     <= '0;
      r_hit_cnt     <= '0;
      r_err         <= 1'b0;
      r_hit_code    <= KEY_NONE;
      r_c0_low0     <= 1'b0;
      r_c1_low0     <= 1'b0;
      r_prev_cand   <= KEY_NONE;
      r_stable      <= '0;
      r_key_pressed <= 1'b0;
      r_key_valid   <= 1'b0;
    end else if (!r_active) begin
      r_active    <= 1'b1;
      r_key_valid <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      r_cnt       <= w_last_dwell ? 16'd0 : r_cnt + 16'd1;

      if (w_last_dwell) begin
        r_col_idx <= r_col_idx + 2'd1;
        if (w_dec_err) r_err <= 1'b1;
        if (w_dec_hit) begin
          r_hit_cnt  <= r_hit_cnt + 3'd1;
          r_hit_code <= w_dec_code;
        end
        if ((r_col_idx == 2'd0) && (key_row_in == ROW_LOW0)) r_c0_low0 <= 1'b1;
        if ((r_col_idx == 2'd1) && (key_row_in == ROW_LOW0)) r_c1_low0 <= 1'b1;
      end

      // Column 0 is already dwelling during RESOLVE, so the accumulator is
      // emptied here before its first sample lands.
      if (w_resolve) begin
        r_hit_cnt   <= '0;
        r_err       <= 1'b0;
        r_hit_code  <= KEY_NONE;
        r_c0_low0   <= 1'b0;
        r_c1_low0   <= 1'b0;
        r_prev_cand <= w_cand;
        r_stable    <= w_stable_nxt;
      end

      if (w_commit) begin
        if (w_cand == KEY_NONE) begin
          r_key_pressed <= 1'b0;
        end else if (!r_key_pressed || (w_cand != r_key_code)) begin
          r_key_code    <= w_cand;
          r_key_pressed <= 1'b1;
          r_key_valid   <= 1'b1;
        end
      end
    end
  end

  assign key_column_out = r_active ? col_strobe(r_col_idx) : COL_OFF;
  assign key_code       = r_key_code;
  assign key_pressed    = r_key_pressed;
  assign key_valid      = r_key_valid;
  assign dbg_state      = r_state;

endmodule
